// File: rtl/csr_unit_if.sv
// CSR access bus between the pipeline (master) and the CSR file (slave).
// Reads are combinational, and writes take effect at the clock edge.
interface csr_unit_if;
    logic        csr_re;
    logic [13:0] csr_num;
    logic [31:0] csr_rvalue;
    logic        csr_we;
    logic [31:0] csr_wmask;
    logic [31:0] csr_wvalue;

    modport master (
        output csr_re, csr_num, csr_we, csr_wmask, csr_wvalue,
        input  csr_rvalue
    );

    modport slave (
        input  csr_re, csr_num, csr_we, csr_wmask, csr_wvalue,
        output csr_rvalue
    );
endinterface

// File: rtl/csr_unit.sv
// Privileged CSR file: mode/exception state, interrupt status, scratch registers
// and a one-shot/periodic countdown timer feeding ESTAT.IS[11].
module csr_unit #(
    parameter logic [31:0] TID_RESET = 32'h0
) (
    input  logic        clk,
    input  logic        reset,
    csr_unit_if.slave   csr,
    input  logic        excp_flush,
    input  logic        ertn_flush,
    input  logic [5:0]  wb_ecode,
    input  logic [8:0]  wb_esubcode,
    input  logic [31:0] wb_pc,
    input  logic [7:0]  hw_int_in,
    input  logic        ipi_int_in,
    output logic [31:0] ex_entry,
    output logic [31:0] era_pc,
    output logic        has_int
);
    localparam logic [13:0] A_CRMD   = 14'h000;
    localparam logic [13:0] A_PRMD   = 14'h001;
    localparam logic [13:0] A_ECFG   = 14'h004;
    localparam logic [13:0] A_ESTAT  = 14'h005;
    localparam logic [13:0] A_ERA    = 14'h006;
    localparam logic [13:0] A_EENTRY = 14'h00C;
    localparam logic [13:0] A_SAVE0  = 14'h030;
    localparam logic [13:0] A_SAVE1  = 14'h031;
    localparam logic [13:0] A_SAVE2  = 14'h032;
    localparam logic [13:0] A_SAVE3  = 14'h033;
    localparam logic [13:0] A_TID    = 14'h040;
    localparam logic [13:0] A_TCFG   = 14'h041;
    localparam logic [13:0] A_TVAL   = 14'h042;
    localparam logic [13:0] A_TICLR  = 14'h044;

    logic [1:0]  r_crmd_plv;
    logic        r_crmd_ie;
    logic [1:0]  r_prmd_pplv;
    logic        r_prmd_pie;
    logic [12:0] r_ecfg_lie;
    logic [1:0]  r_estat_sw;
    logic [7:0]  r_estat_hw;
    logic        r_estat_ti;
    logic        r_estat_ipi;
    logic [5:0]  r_estat_ecode;
    logic [8:0]  r_estat_esub;
    logic [31:0] r_era;
    logic [25:0] r_eentry;
    logic [31:0] r_save [4];
    logic [31:0] r_tid;
    logic        r_tcfg_en;
    logic        r_tcfg_per;
    logic [29:0] r_tcfg_init;
    logic [31:0] r_tval;

    logic [31:0] w_rdata;
    logic [31:0] w_wdata;
    logic        w_wr_crmd, w_wr_prmd, w_wr_ecfg, w_wr_estat, w_wr_era;
    logic        w_wr_eentry, w_wr_tid, w_wr_tcfg, w_wr_ticlr;
    logic        w_expire;

    always_comb begin
        w_rdata = 32'h0;
        case (csr.csr_num)
            A_CRMD:   w_rdata = {28'h0, 1'b1, r_crmd_ie, r_crmd_plv};
            A_PRMD:   w_rdata = {29'h0, r_prmd_pie, r_prmd_pplv};
            A_ECFG:   w_rdata = {19'h0, r_ecfg_lie};
            A_ESTAT:  w_rdata = {1'b0, r_estat_esub, r_estat_ecode, 3'b000, r_estat_ipi,
                                 r_estat_ti, 1'b0, r_estat_hw, r_estat_sw};
            A_ERA:    w_rdata = r_era;
            A_EENTRY: w_rdata = {r_eentry, 6'h00};
            A_SAVE0, A_SAVE1, A_SAVE2, A_SAVE3: w_rdata = r_save[csr.csr_num[1:0]];
            A_TID:    w_rdata = r_tid;
            A_TCFG:   w_rdata = {r_tcfg_init, r_tcfg_per, r_tcfg_en};
            A_TVAL:   w_rdata = r_tval;
            default:  w_rdata = 32'h0;
        endcase
    end

    // Only one CSR is addressed per cycle, so a single merged value serves every write path.
    assign w_wdata        = (w_rdata & ~csr.csr_wmask) | (csr.csr_wvalue & csr.csr_wmask);
    assign csr.csr_rvalue = csr.csr_re ? w_rdata : 32'h0;

    assign w_wr_crmd   = csr.csr_we && (csr.csr_num == A_CRMD);
    assign w_wr_prmd   = csr.csr_we && (csr.csr_num == A_PRMD);
    assign w_wr_ecfg   = csr.csr_we && (csr.csr_num == A_ECFG);
    assign w_wr_estat  = csr.csr_we && (csr.csr_num == A_ESTAT);
    assign w_wr_era    = csr.csr_we && (csr.csr_num == A_ERA);
    assign w_wr_eentry = csr.csr_we && (csr.csr_num == A_EENTRY);
    assign w_wr_tid    = csr.csr_we && (csr.csr_num == A_TID);
    assign w_wr_tcfg   = csr.csr_we && (csr.csr_num == A_TCFG);
    assign w_wr_ticlr  = csr.csr_we && (csr.csr_num == A_TICLR);
    assign w_expire    = r_tcfg_en && (r_tval == 32'h0);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_crmd_plv    <= 2'd0;
            r_crmd_ie     <= 1'b0;
            r_prmd_pplv   <= 2'd0;
            r_prmd_pie    <= 1'b0;
            r_ecfg_lie    <= 13'h0;
            r_estat_sw    <= 2'd0;
            r_estat_hw    <= 8'h0;
            r_estat_ti    <= 1'b0;
            r_estat_ipi   <= 1'b0;
            r_estat_ecode <= 6'h0;
            r_estat_esub  <= 9'h0;
            r_era         <= 32'h0;
            r_eentry      <= 26'h0;
            r_tid         <= TID_RESET;
            r_tcfg_en     <= 1'b0;
            r_tcfg_per    <= 1'b0;
            r_tcfg_init   <= 30'h0;
            r_tval        <= 32'h0;
        end else begin
            // Exception entry owns CRMD/PRMD/ERA/Ecode; ertn only owns CRMD.
            if (excp_flush) begin
                r_crmd_plv    <= 2'd0;
                r_crmd_ie     <= 1'b0;
                r_prmd_pplv   <= r_crmd_plv;
                r_prmd_pie    <= r_crmd_ie;
                r_era         <= wb_pc;
                r_estat_ecode <= wb_ecode;
                r_estat_esub  <= wb_esubcode;
            end else begin
                if (ertn_flush) begin
                    r_crmd_plv <= r_prmd_pplv;
                    r_crmd_ie  <= r_prmd_pie;
                end else if (w_wr_crmd) begin
                    r_crmd_plv <= w_wdata[1:0];
                    r_crmd_ie  <= w_wdata[2];
                end
                if (w_wr_prmd) begin
                    r_prmd_pplv <= w_wdata[1:0];
                    r_prmd_pie  <= w_wdata[2];
                end
                if (w_wr_era) r_era <= w_wdata;
            end

            if (w_wr_ecfg)   r_ecfg_lie <= {w_wdata[12:11], 1'b0, w_wdata[9:0]};
            if (w_wr_estat)  r_estat_sw <= w_wdata[1:0];
            if (w_wr_eentry) r_eentry   <= w_wdata[31:6];
            if (w_wr_tid)    r_tid      <= w_wdata;
            r_estat_hw  <= hw_int_in;
            r_estat_ipi <= ipi_int_in;

            if (w_expire)
                r_estat_ti <= 1'b1;
            else if (w_wr_ticlr && w_wdata[0])
                r_estat_ti <= 1'b0;

            if (w_wr_tcfg) begin
                r_tcfg_en   <= w_wdata[0];
                r_tcfg_per  <= w_wdata[1];
                r_tcfg_init <= w_wdata[31:2];
                if (w_wdata[0]) r_tval <= {w_wdata[31:2], 2'b00};
            end else if (w_expire) begin
                if (r_tcfg_per) r_tval <= {r_tcfg_init, 2'b00};
                else            r_tcfg_en <= 1'b0;
            end else if (r_tcfg_en && (r_tval != 32'h0)) begin
                r_tval <= r_tval - 32'd1;
            end
        end
    end

    for (genvar gi = 0; gi < 4; gi++) begin : g_save
        always_ff @(posedge clk) begin
            if (reset)
                r_save[gi] <= 32'h0;
            else if (csr.csr_we && (csr.csr_num == (A_SAVE0 + 14'(gi))))
                r_save[gi] <= w_wdata;
        end
    end

    assign ex_entry = {r_eentry, 6'h00};
    assign era_pc   = r_era;
    assign has_int  = r_crmd_ie &
                      (|({r_estat_ipi, r_estat_ti, 1'b0, r_estat_hw, r_estat_sw} & r_ecfg_lie));
endmodule

// File: tb/tb_csr_unit.sv
// Randomized and directed bench for csr_unit, checked against an architectural
// model that tracks each CSR as a 32-bit value with per-register writable masks.
`timescale 1ns/1ps
module tb_csr_unit;
    localparam logic [31:0] TID_INIT = 32'hA5A5_0001;

    logic        clk = 1'b0;
    logic        reset;
    logic        excp_flush, ertn_flush;
    logic [5:0]  wb_ecode;
    logic [8:0]  wb_esubcode;
    logic [31:0] wb_pc;
    logic [7:0]  hw_int_in;
    logic        ipi_int_in;
    logic [31:0] ex_entry, era_pc;
    logic        has_int;

    csr_unit_if bus();

    csr_unit #(.TID_RESET(TID_INIT)) dut (
        .clk(clk), .reset(reset), .csr(bus),
        .excp_flush(excp_flush), .ertn_flush(ertn_flush),
        .wb_ecode(wb_ecode), .wb_esubcode(wb_esubcode), .wb_pc(wb_pc),
        .hw_int_in(hw_int_in), .ipi_int_in(ipi_int_in),
        .ex_entry(ex_entry), .era_pc(era_pc), .has_int(has_int)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int txn      = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
        end
    endtask

    // Architectural model state
    logic [31:0] m_crmd, m_prmd, m_ecfg, m_estat, m_era, m_eentry, m_tid, m_tcfg, m_tval;
    logic [31:0] m_save [4];
    logic [31:0] n_crmd, n_prmd, n_ecfg, n_estat, n_era, n_eentry, n_tid, n_tcfg, n_tval;
    logic [31:0] n_save [4];

    task automatic model_reset();
        m_crmd = 32'h8; m_prmd = 0; m_ecfg = 0; m_estat = 0; m_era = 0; m_eentry = 0;
        m_tid = TID_INIT; m_tcfg = 0; m_tval = 0;
        for (int k = 0; k < 4; k++) m_save[k] = 0;
    endtask

    function automatic logic [31:0] mread(input logic [13:0] a);
        case (a)
            14'h000: return m_crmd;
            14'h001: return m_prmd;
            14'h004: return m_ecfg;
            14'h005: return m_estat;
            14'h006: return m_era;
            14'h00C: return m_eentry;
            14'h030, 14'h031, 14'h032, 14'h033: return m_save[a[1:0]];
            14'h040: return m_tid;
            14'h041: return m_tcfg;
            14'h042: return m_tval;
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic [31:0] swr(input logic [31:0] old, input logic [31:0] writable);
        logic [31:0] m;
        m = writable & bus.csr_wmask;
        return (old & ~m) | (bus.csr_wvalue & m);
    endfunction

    function automatic logic exp_has_int();
        return m_crmd[2] & (|(m_estat[12:0] & m_ecfg[12:0]));
    endfunction

    task automatic model_next();
        logic fire, clr;
        n_crmd = m_crmd; n_prmd = m_prmd; n_ecfg = m_ecfg; n_estat = m_estat; n_era = m_era;
        n_eentry = m_eentry; n_tid = m_tid; n_tcfg = m_tcfg; n_tval = m_tval; n_save = m_save;
        if (reset) begin
            n_crmd = 32'h8; n_prmd = 0; n_ecfg = 0; n_estat = 0; n_era = 0; n_eentry = 0;
            n_tid = TID_INIT; n_tcfg = 0; n_tval = 0;
            for (int k = 0; k < 4; k++) n_save[k] = 0;
            return;
        end
        clr = 1'b0;
        if (bus.csr_we) begin
            case (bus.csr_num)
                14'h000: n_crmd   = swr(m_crmd, 32'h7);
                14'h001: n_prmd   = swr(m_prmd, 32'h7);
                14'h004: n_ecfg   = swr(m_ecfg, 32'h1BFF);
                14'h005: n_estat  = swr(m_estat, 32'h3);
                14'h006: n_era    = swr(m_era, 32'hFFFFFFFF);
                14'h00C: n_eentry = swr(m_eentry, 32'hFFFFFFC0);
                14'h030, 14'h031, 14'h032, 14'h033:
                    n_save[bus.csr_num[1:0]] = swr(m_save[bus.csr_num[1:0]], 32'hFFFFFFFF);
                14'h040: n_tid    = swr(m_tid, 32'hFFFFFFFF);
                14'h041: n_tcfg   = swr(m_tcfg, 32'hFFFFFFFF);
                14'h044: clr      = bus.csr_wmask[0] & bus.csr_wvalue[0];
                default: ;
            endcase
        end
        fire = m_tcfg[0] && (m_tval == 0);
        if (bus.csr_we && bus.csr_num == 14'h041) begin
            if (n_tcfg[0]) n_tval = n_tcfg & 32'hFFFFFFFC;
        end else if (fire) begin
            if (m_tcfg[1]) n_tval = m_tcfg & 32'hFFFFFFFC;
            else           n_tcfg[0] = 1'b0;
        end else if (m_tcfg[0] && m_tval != 0) begin
            n_tval = m_tval - 1;
        end
        n_estat[9:2] = hw_int_in;
        n_estat[12]  = ipi_int_in;
        if (fire)     n_estat[11] = 1'b1;
        else if (clr) n_estat[11] = 1'b0;
        if (excp_flush) begin
            n_prmd = {29'h0, m_crmd[2:0]};
            n_crmd = 32'h8;
            n_era  = wb_pc;
            n_estat[21:16] = wb_ecode;
            n_estat[30:22] = wb_esubcode;
        end else if (ertn_flush) begin
            n_crmd = {28'h0, 1'b1, m_prmd[2:0]};
        end
    endtask

    task automatic commit();
        m_crmd = n_crmd; m_prmd = n_prmd; m_ecfg = n_ecfg; m_estat = n_estat; m_era = n_era;
        m_eentry = n_eentry; m_tid = n_tid; m_tcfg = n_tcfg; m_tval = n_tval; m_save = n_save;
    endtask

    task automatic idle();
        bus.csr_re = 0; bus.csr_num = 0; bus.csr_we = 0; bus.csr_wmask = 0; bus.csr_wvalue = 0;
        excp_flush = 0; ertn_flush = 0; wb_ecode = 0; wb_esubcode = 0; wb_pc = 0;
        hw_int_in = 0; ipi_int_in = 0; reset = 0;
    endtask

    task automatic wr(input logic [13:0] a, input logic [31:0] mask, input logic [31:0] val);
        idle();
        bus.csr_we = 1; bus.csr_num = a; bus.csr_wmask = mask; bus.csr_wvalue = val;
    endtask

    // One clock: check combinational outputs against the model, then advance both.
    task automatic tick();
        logic [31:0] exp_rv;
        #1;
        exp_rv = bus.csr_re ? mread(bus.csr_num) : 32'h0;
        check("rvalue", bus.csr_rvalue, exp_rv);
        check("ex_entry", ex_entry, m_eentry);
        check("era_pc", era_pc, m_era);
        check("has_int", {31'h0, has_int}, {31'h0, exp_has_int()});
        $display("txn %0d rst=%0b re=%0b num=%03h we=%0b mask=%08h wval=%08h xf=%0b ef=%0b rv=%08h",
                 txn, reset, bus.csr_re, bus.csr_num, bus.csr_we, bus.csr_wmask, bus.csr_wvalue,
                 excp_flush, ertn_flush, bus.csr_rvalue);
        txn++;
        model_next();
        @(posedge clk);
        #1;
        commit();
    endtask

    task automatic peek(input logic [13:0] a, input logic [31:0] exp, input string tag);
        idle();
        bus.csr_re = 1; bus.csr_num = a;
        #1;
        check(tag, bus.csr_rvalue, exp);
    endtask

    logic [13:0] addrs [17] = '{14'h000, 14'h001, 14'h004, 14'h005, 14'h006, 14'h00C, 14'h030,
                                14'h031, 14'h032, 14'h033, 14'h040, 14'h041, 14'h042, 14'h044,
                                14'h002, 14'h043, 14'h3FFF};
    localparam logic [31:0] EC = 32'h01430000;

    initial begin
        idle();
        reset = 1; bus.csr_we = 1; bus.csr_wmask = '1; bus.csr_wvalue = '1; excp_flush = 1;
        repeat (3) @(posedge clk);
        #1;
        model_reset();
        idle();

        peek(14'h000, 32'h8, "rst_crmd");
        check("rst_ex_entry", ex_entry, 32'h0);
        check("rst_has_int", {31'h0, has_int}, 32'h0);
        tick();
        peek(14'h040, TID_INIT, "rst_tid");
        tick();

        wr(14'h000, 32'h3, 32'hFFFFFFFF); tick();
        peek(14'h000, 32'hB, "crmd_mask");
        wr(14'h00C, 32'hFFFFFFFF, 32'hFFFFFFFF); tick();
        peek(14'h00C, 32'hFFFFFFC0, "eentry_low0");

        wr(14'h00C, 32'hFFFFFFFF, 32'h1C008000); tick();
        wr(14'h000, 32'hFFFFFFFF, 32'h7); tick();
        idle(); excp_flush = 1; wb_pc = 32'h1C000100; wb_ecode = 6'hB; tick();
        peek(14'h006, 32'h1C000100, "excp_era");
        peek(14'h005, 32'h000B0000, "excp_estat");
        peek(14'h001, 32'h7, "excp_prmd");
        tick();
        peek(14'h000, 32'h8, "excp_crmd");
        check("excp_ex_entry", ex_entry, 32'h1C008000);

        idle(); ertn_flush = 1; tick();
        peek(14'h000, 32'hF, "ertn_crmd");
        wr(14'h005, 32'h3, 32'h3);
        excp_flush = 1; ertn_flush = 1; wb_pc = 32'h1C000200; wb_ecode = 6'h3; wb_esubcode = 9'h5;
        tick();
        peek(14'h000, 32'h8, "both_crmd");
        peek(14'h001, 32'h7, "both_prmd");
        peek(14'h005, EC | 32'h3, "both_estat");
        check("both_era", era_pc, 32'h1C000200);
        wr(14'h005, 32'h3, 32'h0); tick();

        wr(14'h041, 32'hFFFFFFFF, 32'h11); tick();
        peek(14'h042, 32'h10, "tval_load");
        idle(); repeat (16) tick();
        peek(14'h042, 32'h0, "tval_zero");
        peek(14'h005, EC, "is11_pre");
        tick();
        peek(14'h005, EC | 32'h800, "is11_set");
        peek(14'h041, 32'h10, "tcfg_en_clr");
        tick();
        peek(14'h042, 32'h0, "tval_hold");

        wr(14'h044, 32'h1, 32'h1); tick();
        peek(14'h005, EC, "ticlr_clear");
        wr(14'h041, 32'hFFFFFFFF, 32'h13); tick();
        idle(); repeat (16) tick();
        wr(14'h044, 32'h1, 32'h1); tick();
        peek(14'h005, EC | 32'h800, "expire_wins");
        peek(14'h042, 32'h10, "periodic_reload");
        peek(14'h041, 32'h13, "periodic_en");

        idle(); repeat (5) tick();
        reset = 1; tick();
        peek(14'h041, 32'h0, "rst_tcfg");
        peek(14'h005, 32'h0, "rst_estat");
        tick(); tick();
        peek(14'h042, 32'h0, "rst_tval_stop");
        tick();

        for (int i = 0; i < 400; i++) begin
            idle();
            reset          = ($urandom_range(0, 199) == 0);
            bus.csr_re     = ($urandom_range(0, 3) != 0);
            bus.csr_num    = addrs[$urandom_range(0, 16)];
            bus.csr_we     = $urandom_range(0, 1) == 1;
            bus.csr_wmask  = ($urandom_range(0, 2) == 0) ? 32'hFFFFFFFF : $urandom;
            bus.csr_wvalue = $urandom;
            if (bus.csr_num == 14'h041) bus.csr_wvalue = $urandom_range(0, 255);
            excp_flush  = ($urandom_range(0, 19) == 0);
            ertn_flush  = ($urandom_range(0, 19) == 0);
            wb_pc       = $urandom;
            wb_ecode    = 6'($urandom);
            wb_esubcode = 9'($urandom);
            hw_int_in   = 8'($urandom);
            ipi_int_in  = $urandom_range(0, 1) == 1;
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
